// File: rtl/spi_pkt_tx_if.sv
// Byte-fetch / SPI-pin bundle between the packet register, the SPI transmitter and the SPI slave.
// The master modport is the transmitter side; the slave modport is the upstream/pin-consumer side.
interface spi_pkt_tx_if;
   logic       start;
   logic [7:0] byte_in;
   logic       byte_req;
   logic       busy;
   logic       done;
   logic       sclk;
   logic       mosi;
   logic       cs_n;

   modport master (
      input  start, byte_in,
      output byte_req, busy, done, sclk, mosi, cs_n
   );

   modport slave (
      output start, byte_in,
      input  byte_req, busy, done, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_pkt_tx.sv
// Mode-0 SPI master that fetches a packet one byte at a time from an upstream register
// and shifts it out MSB-first under a single chip-select frame.
module spi_pkt_tx #(
   parameter int CLK_DIV   = 2,
   parameter int NUM_BYTES = 8
) (
   input  logic         clk,
   input  logic         rst,
   spi_pkt_tx_if.master bus
);
   localparam int DIV_W  = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
   localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

   state_t            state_reg, state_next;
   logic [7:0]        shreg_reg;
   logic [2:0]        bit_cnt_reg;
   logic [BYTE_W-1:0] byte_cnt_reg;
   logic [DIV_W-1:0]  div_cnt_reg;
   logic              sclk_reg;
   logic              cs_n_reg;
   logic              done_reg;

   logic div_wrap;
   logic sclk_fall;
   logic last_bit;
   logic last_byte;

   assign div_wrap  = (div_cnt_reg == DIV_LAST);
   assign sclk_fall = (state_reg == SHIFT) && div_wrap && sclk_reg;
   assign last_bit  = (bit_cnt_reg == 3'd0);
   assign last_byte = (byte_cnt_reg == BYTE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (sclk_fall && last_bit) state_next = last_byte ? FINISH : LOAD;
         FINISH:  if (div_wrap) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.byte_req = (state_reg == LOAD);
      bus.busy     = (state_reg != IDLE);
      bus.done     = done_reg;
      bus.sclk     = sclk_reg;
      bus.mosi     = shreg_reg[7];
      bus.cs_n     = cs_n_reg;
   end

   // Data only moves on SCLK falls, so the slave always samples a settled bit on the rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_reg    <= 8'd0;
         bit_cnt_reg  <= 3'd0;
         byte_cnt_reg <= '0;
         div_cnt_reg  <= '0;
         sclk_reg     <= 1'b0;
         cs_n_reg     <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  cs_n_reg     <= 1'b0;
                  byte_cnt_reg <= '0;
               end
            end
            LOAD: begin
               shreg_reg   <= bus.byte_in;
               bit_cnt_reg <= 3'd7;
               div_cnt_reg <= '0;
            end
            SHIFT: begin
               if (div_wrap) begin
                  div_cnt_reg <= '0;
                  sclk_reg    <= ~sclk_reg;
                  if (sclk_reg) begin
                     if (!last_bit) begin
                        shreg_reg   <= {shreg_reg[6:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg - 3'd1;
                     end else if (!last_byte) begin
                        byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
                     end
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end
            FINISH: begin
               // Hold SCLK low one half-period before releasing chip select.
               if (div_wrap) begin
                  div_cnt_reg <= '0;
                  cs_n_reg    <= 1'b1;
                  done_reg    <= 1'b1;
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_pkt_tx.sv
// Three transmitter instances (D=2/N=8, D=1/N=1, D=3/N=2) checked every cycle against a
// timing-formula model, plus packet-level literal expectations from hand calculation.
module tb_spi_pkt_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v   = 3'b111;
   logic [2:0] start_v = 3'b000;
   logic [2:0] byte_req_v, busy_v, done_v, sclk_v, mosi_v, cs_n_v;
   logic [7:0] byte_in_v [3];
   logic [7:0] src [3][8];
   int         idx [3];
   int         base [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   localparam logic [63:0] PAT = 64'hABACABADABAEABAF;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 2 : (gi == 1) ? 1 : 3;
      localparam int N = (gi == 0) ? 8 : (gi == 1) ? 1 : 2;
      spi_pkt_tx_if bus ();
      assign bus.start      = start_v[gi];
      assign bus.byte_in    = src[gi][3'(idx[gi] - base[gi])];
      assign byte_in_v[gi]  = bus.byte_in;
      assign byte_req_v[gi] = bus.byte_req;
      assign busy_v[gi]     = bus.busy;
      assign done_v[gi]     = bus.done;
      assign sclk_v[gi]     = bus.sclk;
      assign mosi_v[gi]     = bus.mosi;
      assign cs_n_v[gi]     = bus.cs_n;
      spi_pkt_tx #(.CLK_DIV(D), .NUM_BYTES(N)) dut (
         .clk (clk),
         .rst (rst_v[gi]),
         .bus (bus)
      );
   end

   function automatic int dv(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 3;
   endfunction

   function automatic int nv(input int i);
      return (i == 0) ? 8 : (i == 1) ? 1 : 2;
   endfunction

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endfunction

   // Model: cycle offset t from the start edge; byte k spans 16D+1 cycles, FINISH adds D.
   bit         act [3];
   int         t [3];
   logic [7:0] cap [3][8];

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         int p, e;
         p = 16 * dv(i) + 1;
         e = nv(i) * p + dv(i);
         if (rst_v[i]) begin
            act[i] = 1'b0;
         end else if ((!act[i] || t[i] == e) && start_v[i]) begin
            act[i] = 1'b1;
            t[i]   = 0;
         end else if (act[i]) begin
            if (t[i] % p == 0 && t[i] < nv(i) * p) cap[i][t[i] / p] = byte_in_v[i];
            if (t[i] == e) act[i] = 1'b0;
            else           t[i]++;
         end
         if (byte_req_v[i]) idx[i] <= idx[i] + 1;
      end
   end

   function automatic void model_out(input int i, output logic e_req, output logic e_busy,
                                     output logic e_done, output logic e_sclk, output logic e_cs,
                                     output logic e_mosi, output bit mosi_valid);
      int d, n, p, e, k, v;
      d = dv(i); n = nv(i); p = 16 * d + 1; e = n * p + d;
      e_req = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sclk = 1'b0; e_cs = 1'b1;
      e_mosi = 1'b0; mosi_valid = 1'b0;
      if (act[i]) begin
         if (t[i] == e) begin
            e_done = 1'b1;
         end else begin
            e_busy = 1'b1;
            e_cs   = 1'b0;
            if (t[i] < n * p) begin
               k = t[i] / p;
               if (t[i] % p == 0) begin
                  e_req = 1'b1;
               end else begin
                  v          = t[i] % p - 1;
                  e_sclk     = ((v / d) % 2) == 1;
                  e_mosi     = cap[i][k][7 - v / (2 * d)];
                  mosi_valid = 1'b1;
               end
            end
         end
      end
   endfunction

   // Packet statistics gathered by a bench-side SPI slave
   logic [63:0] rx [3];
   int rises [3], reqs [3], cslow [3], dones [3], last_rise [3], last_fall [3];
   int rise_c [2];
   int lows2 [$];
   int highs2 [$];
   logic [2:0] sclk_prev = 3'b000;
   logic e_req, e_busy, e_done, e_sclk, e_cs, e_mosi;
   bit   mv;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            model_out(i, e_req, e_busy, e_done, e_sclk, e_cs, e_mosi, mv);
            check($sformatf("byte_req[%0d]", i), byte_req_v[i], e_req);
            check($sformatf("busy[%0d]", i),     busy_v[i],     e_busy);
            check($sformatf("done[%0d]", i),     done_v[i],     e_done);
            check($sformatf("sclk[%0d]", i),     sclk_v[i],     e_sclk);
            check($sformatf("cs_n[%0d]", i),     cs_n_v[i],     e_cs);
            if (mv) check($sformatf("mosi[%0d]", i), mosi_v[i], e_mosi);
            if (!cs_n_v[i])    cslow[i]++;
            if (byte_req_v[i]) reqs[i]++;
            if (done_v[i])     dones[i]++;
            if (sclk_v[i] && !sclk_prev[i]) begin
               rx[i] = {rx[i][62:0], mosi_v[i]};
               if (i == 1 && rises[i] < 2) rise_c[rises[i]] = cyc;
               if (i == 2 && rises[i] > 0) lows2.push_back(cyc - last_fall[i]);
               last_rise[i] = cyc;
               rises[i]++;
            end
            if (!sclk_v[i] && sclk_prev[i]) begin
               if (i == 2) highs2.push_back(cyc - last_rise[i]);
               last_fall[i] = cyc;
            end
            sclk_prev[i] = sclk_v[i];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats(input int i);
      rx[i] = '0; rises[i] = 0; reqs[i] = 0; cslow[i] = 0; dones[i] = 0;
      base[i] = idx[i];
      if (i == 2) begin
         lows2.delete();
         highs2.delete();
      end
   endtask

   task automatic pulse_start(input int i);
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done_v[i]) begin
            seen = 1'b1;
            break;
         end
      end
      #1;
      check($sformatf("done_seen[%0d]", i), seen, 1'b1);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin
         src[0][k] = PAT[63 - 8 * k -: 8];
         src[1][k] = 8'h80;
         src[2][k] = 8'h00;
      end
      src[2][0] = 8'h5A;
      src[2][1] = 8'hC3;

      // Reset state
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_cs_n", cs_n_v[0], 1'b1);
      check("rst_sclk", sclk_v[0], 1'b0);
      check("rst_mosi", mosi_v[0], 1'b0);
      check("rst_busy", busy_v[0], 1'b0);
      check("rst_done", done_v[0], 1'b0);
      rst_v = 3'b000;
      tick();

      // Default packet
      clear_stats(0);
      pulse_start(0);
      wait_done(0, 400);
      tick();
      check("pkt_data",  rx[0],    PAT);
      check("pkt_rises", rises[0], 64);
      check("pkt_reqs",  reqs[0],  8);
      check("pkt_cslow", cslow[0], 266);
      check("pkt_dones", dones[0], 1);

      // Single 0x80 byte, CLK_DIV=1
      clear_stats(1);
      pulse_start(1);
      wait_done(1, 100);
      tick();
      check("b80_data",   rx[1][7:0], 8'h80);
      check("b80_rises",  rises[1],   8);
      check("b80_cslow",  cslow[1],   18);
      check("b80_period", rise_c[1] - rise_c[0], 2);

      // CLK_DIV=3 phase lengths
      clear_stats(2);
      pulse_start(2);
      wait_done(2, 300);
      tick();
      check("d3_data",      rx[2][15:0],  16'h5AC3);
      check("d3_lows_n",    lows2.size(), 15);
      check("d3_high0",     highs2[0],    3);
      check("d3_low0",      lows2[0],     3);
      check("d3_low6",      lows2[6],     3);
      check("d3_boundary",  lows2[7],     4);
      check("d3_cslow",     cslow[2],     101);

      // start held high through a packet
      clear_stats(0);
      start_v[0] = 1'b1;
      wait_done(0, 400);
      check("held_reqs", reqs[0], 8);
      @(negedge clk);
      #1;
      check("held_restart_req", byte_req_v[0], 1'b1);
      start_v[0] = 1'b0;
      wait_done(0, 400);
      tick();
      check("held_reqs2",  reqs[0],  16);
      check("held_dones",  dones[0], 2);
      check("held_data2",  rx[0],    PAT);

      // Reset in the middle of byte 3, bit 4
      clear_stats(0);
      pulse_start(0);
      begin
         bit hit;
         hit = 1'b0;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (reqs[0] == 4) begin
               hit = 1'b1;
               break;
            end
         end
         check("mid_reach_byte3", hit, 1'b1);
      end
      repeat (13) @(posedge clk);
      #1;
      check("mid_busy_before", busy_v[0], 1'b1);
      rst_v[0] = 1'b1;
      tick();
      check("mid_rst_cs_n", cs_n_v[0], 1'b1);
      check("mid_rst_sclk", sclk_v[0], 1'b0);
      check("mid_rst_mosi", mosi_v[0], 1'b0);
      check("mid_rst_busy", busy_v[0], 1'b0);
      check("mid_rst_done", done_v[0], 1'b0);
      rst_v[0] = 1'b0;
      tick();
      clear_stats(0);
      pulse_start(0);
      wait_done(0, 400);
      tick();
      check("restart_data", rx[0],   PAT);
      check("restart_reqs", reqs[0], 8);

      // start and rst together from IDLE
      rst_v[0]   = 1'b1;
      start_v[0] = 1'b1;
      tick();
      rst_v[0]   = 1'b0;
      start_v[0] = 1'b0;
      check("rst_start_cs_n", cs_n_v[0], 1'b1);
      check("rst_start_busy", busy_v[0], 1'b0);
      tick();
      check("rst_start_cs_n2", cs_n_v[0],     1'b1);
      check("rst_start_req",   byte_req_v[0], 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
